// File: rtl/cmd_queue_if.sv
// Level-handshake bundle for cmd_queue: upstream capture from UART_wrapper and
// downstream head/pop toward the command consumer.
interface cmd_queue_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0] cmd_in;
    logic             cmd_rdy_in;
    logic             clr_in;
    logic [WIDTH-1:0] cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;

    modport master (
        output cmd_in, cmd_rdy_in, clr_cmd_rdy,
        input  clr_in, cmd, cmd_rdy
    );

    modport slave (
        input  cmd_in, cmd_rdy_in, clr_cmd_rdy,
        output clr_in, cmd, cmd_rdy
    );
endinterface

// File: rtl/cmd_queue.sv
// Command FIFO between UART_wrapper and the command consumer; lets the host
// queue up to DEPTH commands ahead while the current one is executing.
module cmd_queue #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    cmd_queue_if.slave    bus,
    input  logic          flush,
    output logic          full,
    output logic [CW-1:0] count,
    output logic [CW-1:0] peak
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    peak_q, peak_d;
    logic             clr_q, clr_d;
    logic             push, pop;
    logic             full_c;

    assign full_c = (count_q == CW'(DEPTH));

    // Push uses the pre-pop full flag; clr_q blocks re-capture during the handshake.
    always_comb begin
        push    = bus.cmd_rdy_in & ~clr_q & ~full_c & ~flush;
        pop     = bus.clr_cmd_rdy & (count_q != '0) & ~flush;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        clr_d   = push;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = wp_q + PW'(1);
            if (pop)  rp_d = rp_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
        peak_d = (count_d > peak_q) ? count_d : peak_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            peak_q  <= '0;
            clr_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            peak_q  <= peak_d;
            clr_q   <= clr_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wp_q] <= bus.cmd_in;
    end

    assign bus.cmd     = (count_q == '0) ? '0 : mem_q[rp_q];
    assign bus.cmd_rdy = (count_q != '0);
    assign bus.clr_in  = clr_q;
    assign full        = full_c;
    assign count       = count_q;
    assign peak        = peak_q;

endmodule

// File: tb/tb_cmd_queue.sv
// Scoreboard bench for cmd_queue: words are queued as they are offered and
// compared against the head whenever the consumer pops.
module tb_cmd_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          full;
    logic [CW-1:0] count;
    logic [CW-1:0] peak;

    cmd_queue_if #(.WIDTH(WIDTH)) bus ();

    cmd_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .flush (flush),
        .full  (full),
        .count (count),
        .peak  (peak)
    );

    always #10 clk = ~clk;

    int unsigned     n_checks = 0;
    int unsigned     n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic            last_clr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle; the UART model drops cmd_rdy_in once it sees clr_in.
    task automatic tick();
        @(negedge clk);
        last_clr = bus.clr_in;
        if (bus.clr_in) bus.cmd_rdy_in = 1'b0;
    endtask

    task automatic load(input logic [WIDTH-1:0] w);
        bus.cmd_in     = w;
        bus.cmd_rdy_in = 1'b1;
        exp_q.push_back(w);
    endtask

    task automatic wait_clr(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_clr && n < budget);
        chk("capture", 32'(last_clr), 32'd1);
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        load(w);
        wait_clr(8);
    endtask

    task automatic pop_check();
        logic [WIDTH-1:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk("cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
        chk("head", 32'(bus.cmd), 32'(e));
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.cmd_rdy_in  = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.cmd_in      = '0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_peak", 32'(peak), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("rst_clr_in", 32'(bus.clr_in), 32'd0);
        chk("rst_cmd", 32'(bus.cmd), 32'd0);

        // Single command
        send(16'h2002);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_cmd", 32'(bus.cmd), 32'h2002);
        tick();
        chk("t1_clr_one_cycle", 32'(last_clr), 32'd0);
        pop_check();
        chk("t1_count_after_pop", 32'(count), 32'd0);
        chk("t1_rdy_after_pop", 32'(bus.cmd_rdy), 32'd0);

        // Overflow stall: fifth word waits until a slot frees
        for (int i = 1; i <= 4; i++) send(16'(16'h1000 + i));
        tick();
        chk("t2_count_full", 32'(count), 32'd4);
        chk("t2_full", 32'(full), 32'd1);
        load(16'h1005);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_no_clr_while_full", 32'(last_clr), 32'd0);
        end
        chk("t2_count_stalled", 32'(count), 32'd4);
        pop_check();
        chk("t2_no_capture_on_pop", 32'(last_clr), 32'd0);
        chk("t2_count_after_pop", 32'(count), 32'd3);
        tick();
        chk("t2_late_capture", 32'(last_clr), 32'd1);
        chk("t2_count_refill", 32'(count), 32'd4);
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) pop_check();
        chk("t2_empty", 32'(count), 32'd0);
        chk("t2_peak", 32'(peak), 32'd4);

        // Simultaneous push and pop at count=1
        send(16'hA0A0);
        tick();
        load(16'hB0B0);
        pop_check();
        chk("t3_count", 32'(count), 32'd1);
        chk("t3_clr", 32'(last_clr), 32'd1);
        chk("t3_cmd", 32'(bus.cmd), 32'hB0B0);
        tick();
        pop_check();
        chk("t3_empty", 32'(count), 32'd0);

        // Pop on empty queue is ignored
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_rdy", 32'(bus.cmd_rdy), 32'd0);
        chk("t4_cmd", 32'(bus.cmd), 32'd0);
        send(16'h4444);
        chk("t4_count_push", 32'(count), 32'd1);
        tick();
        pop_check();

        // Flush with a pending UART word
        do_reset();
        for (int i = 1; i <= 3; i++) send(16'(16'h5000 + i));
        tick();
        chk("t5_count_pre", 32'(count), 32'd3);
        exp_q.delete();
        load(16'h5555);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_count_flush", 32'(count), 32'd0);
        chk("t5_no_clr", 32'(last_clr), 32'd0);
        chk("t5_rdy_flush", 32'(bus.cmd_rdy), 32'd0);
        tick();
        chk("t5_capture", 32'(last_clr), 32'd1);
        chk("t5_count", 32'(count), 32'd1);
        chk("t5_peak", 32'(peak), 32'd3);
        pop_check();

        // Reset mid-burst with clr_in pending
        send(16'h6001);
        tick();
        send(16'h6002);
        chk("t6_count_pre", 32'(count), 32'd2);
        rst_n = 1'b0;
        tick();
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_peak", 32'(peak), 32'd0);
        chk("t6_clr_in", 32'(bus.clr_in), 32'd0);
        chk("t6_rdy", 32'(bus.cmd_rdy), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        bus.cmd_rdy_in = 1'b0;

        // Pointer wrap
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            send(16'($urandom_range(1, 16'hFFFF)));
            tick();
            pop_check();
        end
        chk("wrap_empty", 32'(count), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
